// File: rtl/thread_issue_sched.sv
// Multithreaded issue scheduler: per-thread fetch FIFOs, round-robin pick onto a
// registered decode output that holds under stall, with per-thread branch blocking.
module thread_issue_sched #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int FIFO_DEPTH  = 2,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_THREADS-1:0]      fetch_valid_i,
    input  logic [NUM_THREADS*32-1:0]   fetch_instr_i,
    input  logic [NUM_THREADS*XLEN-1:0] fetch_pc_i,
    output logic [NUM_THREADS-1:0]      fetch_ready_o,
    input  logic                        stall_i,
    output logic                        issue_valid_o,
    output logic [31:0]                 issue_instr_o,
    output logic [XLEN-1:0]             issue_pc_o,
    output logic [TID_W-1:0]            issue_thread_id_o,
    input  logic                        resolve_valid_i,
    input  logic [TID_W-1:0]            resolve_tid_i,
    input  logic [NUM_THREADS-1:0]      flush_i,
    output logic [NUM_THREADS-1:0]      blocked_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [31:0]      instr_mem_q [NUM_THREADS][FIFO_DEPTH];
    logic [31:0]      instr_mem_d [NUM_THREADS][FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem_q    [NUM_THREADS][FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem_d    [NUM_THREADS][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_THREADS], wr_ptr_d [NUM_THREADS];
    logic [PTR_W-1:0] rd_ptr_q [NUM_THREADS], rd_ptr_d [NUM_THREADS];
    logic [CNT_W-1:0] cnt_q    [NUM_THREADS], cnt_d    [NUM_THREADS];

    logic [NUM_THREADS-1:0] blocked_q, blocked_d;
    logic [TID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [31:0]            issue_instr_q, issue_instr_d;
    logic [XLEN-1:0]        issue_pc_q, issue_pc_d;
    logic [TID_W-1:0]       issue_tid_q, issue_tid_d;

    logic [NUM_THREADS-1:0] eligible, push, pop;
    logic                   load, grant_vld;
    logic [TID_W-1:0]       grant_tid, cand_tid;
    logic [31:0]            head_instr;
    logic [XLEN-1:0]        head_pc;

    function automatic logic is_ctrl_flow(input logic [31:0] instr);
        return (instr[6:0] == 7'b1101111) || (instr[6:0] == 7'b1100111) ||
               (instr[6:0] == 7'b1100011);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A flushing thread is neither eligible nor ready, so its push is dropped.
    always_comb begin
        fetch_ready_o = '0;
        eligible      = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            fetch_ready_o[t] = !rst && !flush_i[t] && (cnt_q[t] != FULL_CNT);
            eligible[t]      = (cnt_q[t] != '0) && !blocked_q[t] && !flush_i[t];
        end
    end

    assign load = !issue_valid_q || !stall_i;

    always_comb begin
        grant_vld = 1'b0;
        grant_tid = '0;
        cand_tid  = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cand_tid = rr_ptr_q + TID_W'(i);
            if (!grant_vld && eligible[cand_tid]) begin
                grant_vld = 1'b1;
                grant_tid = cand_tid;
            end
        end
    end

    assign head_instr = instr_mem_q[grant_tid][rd_ptr_q[grant_tid]];
    assign head_pc    = pc_mem_q[grant_tid][rd_ptr_q[grant_tid]];

    always_comb begin
        push        = '0;
        pop         = '0;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            push[t] = fetch_valid_i[t] && fetch_ready_o[t];
            pop[t]  = load && grant_vld && (grant_tid == TID_W'(t));
            if (push[t]) begin
                instr_mem_d[t][wr_ptr_q[t]] = fetch_instr_i[32*t +: 32];
                pc_mem_d[t][wr_ptr_q[t]]    = fetch_pc_i[XLEN*t +: XLEN];
                wr_ptr_d[t]                 = ptr_inc(wr_ptr_q[t]);
            end
            if (pop[t]) rd_ptr_d[t] = ptr_inc(rd_ptr_q[t]);
            cnt_d[t] = cnt_q[t] + CNT_W'(push[t]) - CNT_W'(pop[t]);
            if (flush_i[t]) begin
                wr_ptr_d[t] = '0;
                rd_ptr_d[t] = '0;
                cnt_d[t]    = '0;
            end
        end
    end

    // Resolve clears first so a same-cycle control-flow grant keeps the thread blocked.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        issue_pc_d    = issue_pc_q;
        issue_tid_d   = issue_tid_q;
        rr_ptr_d      = rr_ptr_q;
        blocked_d     = blocked_q;
        if (resolve_valid_i) blocked_d[resolve_tid_i] = 1'b0;
        if (load) begin
            issue_valid_d = grant_vld;
            if (grant_vld) begin
                issue_instr_d = head_instr;
                issue_pc_d    = head_pc;
                issue_tid_d   = grant_tid;
                rr_ptr_d      = grant_tid + 1'b1;
                if (is_ctrl_flow(head_instr)) blocked_d[grant_tid] = 1'b1;
            end
        end else if (flush_i[issue_tid_q]) begin
            issue_valid_d = 1'b0;
        end
        blocked_d = blocked_d & ~flush_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '{default: '0};
            rd_ptr_q      <= '{default: '0};
            cnt_q         <= '{default: '0};
            blocked_q     <= '0;
            rr_ptr_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_pc_q    <= '0;
            issue_tid_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            blocked_q     <= blocked_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_pc_q    <= issue_pc_d;
            issue_tid_q   <= issue_tid_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

    assign issue_valid_o     = issue_valid_q;
    assign issue_instr_o     = issue_instr_q;
    assign issue_pc_o        = issue_pc_q;
    assign issue_thread_id_o = issue_tid_q;
    assign blocked_o         = blocked_q;

endmodule

// File: tb/tb_thread_issue_sched.sv
// Bench for thread_issue_sched: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the scheduler.
module tb_thread_issue_sched;
    localparam int N     = 4;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TID_W = 2;
    localparam logic [31:0] JAL = 32'h0080006F;
    localparam logic [31:0] BEQ = 32'h00208463;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      fetch_valid;
    logic [N*32-1:0]   fetch_instr;
    logic [N*XLEN-1:0] fetch_pc;
    logic [N-1:0]      fetch_ready;
    logic              stall;
    logic              issue_valid;
    logic [31:0]       issue_instr;
    logic [XLEN-1:0]   issue_pc;
    logic [TID_W-1:0]  issue_tid;
    logic              resolve_valid;
    logic [TID_W-1:0]  resolve_tid;
    logic [N-1:0]      flush;
    logic [N-1:0]      blocked;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t            mq [N][$];
    logic [N-1:0]    m_blocked;
    int              m_rr;
    logic            m_valid;
    logic [31:0]     m_instr;
    logic [XLEN-1:0] m_pc;
    int              m_tid;

    thread_issue_sched #(.NUM_THREADS(N), .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .TID_W(TID_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr), .fetch_pc_i(fetch_pc),
        .fetch_ready_o(fetch_ready), .stall_i(stall),
        .issue_valid_o(issue_valid), .issue_instr_o(issue_instr), .issue_pc_o(issue_pc),
        .issue_thread_id_o(issue_tid), .resolve_valid_i(resolve_valid),
        .resolve_tid_i(resolve_tid), .flush_i(flush), .blocked_o(blocked)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] alu(input int t, input int k);
        return 32'h00000033 | (32'(t) << 7) | (32'(k) << 20);
    endfunction

    // Reference: each thread is a bounded queue; the scheduler takes the first
    // non-empty, unblocked, unflushed thread at or after the round-robin point.
    task automatic model_step();
        logic [N-1:0] rdy;
        int g, c;
        ent_t e;
        if (rst) begin
            for (int t = 0; t < N; t++) mq[t].delete();
            m_blocked = '0; m_rr = 0; m_valid = 1'b0;
            m_instr = '0; m_pc = '0; m_tid = 0;
            return;
        end
        for (int t = 0; t < N; t++) rdy[t] = !flush[t] && (mq[t].size() < DEPTH);
        g = -1;
        for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (g < 0 && mq[c].size() > 0 && !m_blocked[c] && !flush[c]) g = c;
        end
        if (resolve_valid) m_blocked[resolve_tid] = 1'b0;
        if (!m_valid || !stall) begin
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_valid = 1'b1; m_instr = e.instr; m_pc = e.pc; m_tid = g;
                m_rr = (g + 1) % N;
                if (e.instr[6:0] inside {7'h6F, 7'h67, 7'h63}) m_blocked[g] = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else if (m_valid && flush[m_tid]) begin
            m_valid = 1'b0;
        end
        for (int t = 0; t < N; t++) begin
            if (flush[t]) begin
                mq[t].delete();
                m_blocked[t] = 1'b0;
            end else if (fetch_valid[t] && rdy[t]) begin
                e = {fetch_instr[32*t +: 32], fetch_pc[XLEN*t +: XLEN]};
                mq[t].push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(input int t, input logic v, input logic [31:0] ins,
                              input logic [XLEN-1:0] pc);
        fetch_valid[t]             = v;
        fetch_instr[32*t +: 32]    = ins;
        fetch_pc[XLEN*t +: XLEN]   = pc;
    endtask

    task automatic idle();
        fetch_valid = '0; fetch_instr = '0; fetch_pc = '0;
        stall = 1'b0; resolve_valid = 1'b0; resolve_tid = '0; flush = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_cmp++; if (fetch_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", fetch_ready); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
        n_cmp++; if (issue_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", issue_instr); end
        n_cmp++; if (issue_pc !== '0) begin n_err++; $display("FAIL reset_pc: got %h want 0", issue_pc); end
        n_cmp++; if (issue_tid !== '0) begin n_err++; $display("FAIL reset_tid: got %0d want 0", issue_tid); end
        n_cmp++; if (blocked !== 4'b0000) begin n_err++; $display("FAIL reset_blocked: got %b want 0000", blocked); end
        rst = 1'b0;
        #1;
        n_cmp++; if (fetch_ready !== 4'b1111) begin n_err++; $display("FAIL post_reset_ready: got %b want 1111", fetch_ready); end
    endtask

    task automatic test_latency();
        drive_lane(2, 1'b1, 32'h00100093, 32'h100);
        tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", issue_valid); end
        drive_lane(2, 1'b0, '0, '0);
        tick();
        n_cmp++; if (issue_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b want 1", issue_valid); end
        n_cmp++; if (issue_instr !== 32'h00100093) begin n_err++; $display("FAIL lat_instr: got %h want 00100093", issue_instr); end
        n_cmp++; if (issue_pc !== 32'h100) begin n_err++; $display("FAIL lat_pc: got %h want 100", issue_pc); end
        n_cmp++; if (issue_tid !== 2'd2) begin n_err++; $display("FAIL lat_tid: got %0d want 2", issue_tid); end
        tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL lat_drain: got %b want 0", issue_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < N; t++) drive_lane(t, 1'b1, alu(t, k), 32'h1000 + 32'(t * 16 + k * 4));
            tick();
        end
        fetch_valid = '0;
        for (int j = 0; j < 8; j++) begin
            n_cmp++; if (issue_valid !== 1'b1 || issue_tid !== TID_W'(j % N) || issue_instr !== alu(j % N, j / N)) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got v=%b tid=%0d instr=%h want v=1 tid=%0d instr=%h",
                         j, issue_valid, issue_tid, issue_instr, j % N, alu(j % N, j / N));
            end
            tick();
        end
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %b want 0", issue_valid); end
    endtask

    task automatic test_branch_block();
        do_reset();
        drive_lane(1, 1'b1, BEQ, 32'h200);
        tick();
        drive_lane(1, 1'b1, 32'h00208133, 32'h204);
        tick();
        fetch_valid = '0;
        n_cmp++; if (issue_valid !== 1'b1 || issue_instr !== BEQ || issue_tid !== 2'd1) begin
            n_err++; $display("FAIL br_issue: got v=%b instr=%h tid=%0d want v=1 instr=%h tid=1", issue_valid, issue_instr, issue_tid, BEQ);
        end
        n_cmp++; if (blocked !== 4'b0010) begin n_err++; $display("FAIL br_blocked: got %b want 0010", blocked); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (issue_valid !== 1'b0 || blocked[1] !== 1'b1) begin
                n_err++; $display("FAIL br_wait[%0d]: got v=%b blk=%b want v=0 blk=1", c, issue_valid, blocked[1]);
            end
        end
        resolve_valid = 1'b1; resolve_tid = 2'd1;
        tick();
        resolve_valid = 1'b0;
        n_cmp++; if (blocked !== 4'b0000 || issue_valid !== 1'b0) begin
            n_err++; $display("FAIL br_resolve: got blk=%b v=%b want blk=0000 v=0", blocked, issue_valid);
        end
        tick();
        n_cmp++; if (issue_valid !== 1'b1 || issue_instr !== 32'h00208133 || issue_pc !== 32'h204 || issue_tid !== 2'd1) begin
            n_err++; $display("FAIL br_after: got v=%b instr=%h pc=%h tid=%0d want v=1 instr=00208133 pc=204 tid=1",
                              issue_valid, issue_instr, issue_pc, issue_tid);
        end
    endtask

    task automatic test_stall_hold();
        int k;
        logic acc;
        do_reset();
        drive_lane(0, 1'b1, alu(0, 0), 32'h300);
        tick();
        drive_lane(0, 1'b1, alu(0, 1), 32'h304);
        tick();
        k = 2;
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_lane(0, 1'b1, alu(0, k), 32'h300 + 32'(4 * k));
            acc = fetch_ready[0];
            tick();
            if (acc) k++;
            n_cmp++; if (issue_valid !== 1'b1 || issue_instr !== alu(0, 0) || issue_pc !== 32'h300 || issue_tid !== 2'd0) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h tid=%0d want v=1 instr=%h pc=300 tid=0",
                                  c, issue_valid, issue_instr, issue_pc, issue_tid, alu(0, 0));
            end
        end
        n_cmp++; if (fetch_ready[0] !== 1'b0) begin n_err++; $display("FAIL stall_full: got %b want 0", fetch_ready[0]); end
        stall = 1'b0;
        fetch_valid = '0;
        for (int j = 1; j <= 2; j++) begin
            tick();
            n_cmp++; if (issue_valid !== 1'b1 || issue_instr !== alu(0, j) || issue_pc !== 32'h300 + 32'(4 * j)) begin
                n_err++; $display("FAIL stall_resume[%0d]: got v=%b instr=%h pc=%h want v=1 instr=%h", j, issue_valid, issue_instr, issue_pc, alu(0, j));
            end
        end
        tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", issue_valid); end
    endtask

    task automatic test_flush_held();
        do_reset();
        drive_lane(3, 1'b1, JAL, 32'h400);
        tick();
        drive_lane(3, 1'b1, alu(3, 1), 32'h404);
        tick();
        stall = 1'b1;
        drive_lane(3, 1'b1, alu(3, 2), 32'h408);
        tick();
        drive_lane(3, 1'b1, alu(3, 3), 32'h40C);
        n_cmp++; if (issue_valid !== 1'b1 || issue_tid !== 2'd3 || issue_instr !== JAL) begin
            n_err++; $display("FAIL fl_pre_issue: got v=%b tid=%0d instr=%h want v=1 tid=3 instr=%h", issue_valid, issue_tid, issue_instr, JAL);
        end
        n_cmp++; if (blocked[3] !== 1'b1 || fetch_ready[3] !== 1'b0) begin
            n_err++; $display("FAIL fl_pre_state: got blk=%b rdy=%b want blk=1 rdy=0", blocked[3], fetch_ready[3]);
        end
        flush[3] = 1'b1;
        tick();
        n_cmp++; if (issue_valid !== 1'b0 || blocked[3] !== 1'b0) begin
            n_err++; $display("FAIL fl_clear: got v=%b blk=%b want v=0 blk=0", issue_valid, blocked[3]);
        end
        flush = '0;
        fetch_valid = '0;
        #1;
        n_cmp++; if (fetch_ready[3] !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b want 1", fetch_ready[3]); end
        stall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL fl_empty[%0d]: got v=%b want 0", c, issue_valid); end
        end
    endtask

    task automatic test_resolve_set_wins();
        do_reset();
        drive_lane(0, 1'b1, JAL, 32'h500);
        tick();
        fetch_valid = '0;
        resolve_valid = 1'b1; resolve_tid = 2'd0;
        tick();
        resolve_valid = 1'b0;
        n_cmp++; if (blocked[0] !== 1'b1 || issue_valid !== 1'b1 || issue_instr !== JAL) begin
            n_err++; $display("FAIL set_wins: got blk=%b v=%b instr=%h want blk=1 v=1 instr=%h", blocked[0], issue_valid, issue_instr, JAL);
        end
        resolve_valid = 1'b1; resolve_tid = 2'd0;
        tick();
        resolve_valid = 1'b0;
        n_cmp++; if (blocked[0] !== 1'b0) begin n_err++; $display("FAIL set_then_resolve: got %b want 0", blocked[0]); end
    endtask

    task automatic test_random();
        logic [31:0] r32;
        logic [6:0]  op;
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 199) == 0) || (cyc == 300);
            for (int t = 0; t < N; t++) begin
                r32 = $urandom();
                case ($urandom_range(0, 9))
                    0: op = 7'b1101111;
                    1: op = 7'b1100111;
                    2: op = 7'b1100011;
                    default: op = 7'b0110011;
                endcase
                drive_lane(t, ($urandom_range(0, 9) < 6), {r32[31:7], op}, $urandom());
                flush[t] = ($urandom_range(0, 29) == 0);
            end
            stall = ($urandom_range(0, 3) == 0);
            resolve_valid = ($urandom_range(0, 2) == 0);
            resolve_tid = TID_W'($urandom_range(0, N - 1));
            tick();
            n_cmp++; if (issue_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, issue_valid, m_valid);
            end
            if (m_valid) begin
                n_cmp++; if (issue_instr !== m_instr || issue_pc !== m_pc || issue_tid !== TID_W'(m_tid)) begin
                    n_err++; $display("FAIL rnd_data@%0d: got instr=%h pc=%h tid=%0d want instr=%h pc=%h tid=%0d",
                                      cyc, issue_instr, issue_pc, issue_tid, m_instr, m_pc, m_tid);
                end
            end
            n_cmp++; if (blocked !== m_blocked) begin
                n_err++; $display("FAIL rnd_blocked@%0d: got %b want %b", cyc, blocked, m_blocked);
            end
            for (int t = 0; t < N; t++) exp_rdy[t] = !rst && !flush[t] && (mq[t].size() < DEPTH);
            n_cmp++; if (fetch_ready !== exp_rdy) begin
                n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, fetch_ready, exp_rdy);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_latency();
        test_round_robin();
        test_branch_block();
        test_stall_hold();
        test_flush_held();
        test_resolve_set_wins();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
